ntt8_bitrev_reorder: RTL and testbench

// - Output stage directly downstream of the 8-point SDF NTT pipeline; consumes its serial,
//   bit-reversed-order coefficient stream (one word per accepted beat, 8 beats per frame).
// - Ping-pong buffer: writes each frame at bit-reversed address, replays it in natural order

---
 rtl/ntt8_bitrev_reorder.sv | 100 ++++++++++
 tb/tb_ntt8_bitrev_reorder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ntt8_bitrev_reorder.sv
// ntt8_bitrev_reorder: ping-pong buffer turning a bit-reversed NTT output stream into natural order.
// Optional `REORDER_BYPASS_EN adds a per-frame bypass input that writes the frame in natural order.
module ntt8_bitrev_reorder #(
    parameter int DATA_W = 16,
    parameter int LOG_N  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef REORDER_BYPASS_EN
    input  logic              bypass,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              frame_done
);
    localparam int N = 1 << LOG_N;
    logic [DATA_W-1:0] mem_q [2][N];
    logic [DATA_W-1:0] mem_d [2][N];
    logic [1:0]        full_q, full_d;
    logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [LOG_N-1:0]  wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic              frame_done_q, frame_done_d;
    logic [LOG_N-1:0]  wr_rev, wr_addr;
    logic              in_fire, out_fire, wr_byp;
`ifdef REORDER_BYPASS_EN
    logic [1:0]        byp_q, byp_d;
`endif
    always_comb begin
        in_ready   = !full_q[wr_bank_q];
        out_valid  = full_q[rd_bank_q];
        out_data   = mem_q[rd_bank_q][rd_cnt_q];
        out_last   = out_valid & (&rd_cnt_q);
        frame_done = frame_done_q;
        in_fire    = in_valid & in_ready;
        out_fire   = out_valid & out_ready;
        for (int i = 0; i < LOG_N; i++) wr_rev[i] = wr_cnt_q[LOG_N-1-i];
`ifdef REORDER_BYPASS_EN
        // The bypass choice is latched with the first word so a frame is never split between orders.
        wr_byp = (wr_cnt_q == '0) ? bypass : byp_q[wr_bank_q];
        byp_d  = byp_q;
        if (in_fire && wr_cnt_q == '0) byp_d[wr_bank_q] = bypass;
`else
        wr_byp = 1'b0;
`endif
        wr_addr      = wr_byp ? wr_cnt_q : wr_rev;
        mem_d        = mem_q;
        full_d       = full_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        frame_done_d = 1'b0;
        if (in_fire) begin
            mem_d[wr_bank_q][wr_addr] = in_data;
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (&wr_cnt_q) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d = !wr_bank_q;
            end
        end
        // Write and read banks always differ here, so a simultaneous set and clear never collide.
        if (out_fire) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
            if (&rd_cnt_q) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d = !rd_bank_q;
                frame_done_d = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q       <= '0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            frame_done_q <= 1'b0;
`ifdef REORDER_BYPASS_EN
            byp_q        <= '0;
`endif
        end else begin
            full_q       <= full_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            frame_done_q <= frame_done_d;
`ifdef REORDER_BYPASS_EN
            byp_q        <= byp_d;
`endif
        end
    end
    always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: tb/tb_ntt8_bitrev_reorder.sv
// tb_ntt8_bitrev_reorder: scoreboard bench; expected natural-order words queued as each input frame completes.
module tb_ntt8_bitrev_reorder;
    localparam int DW = 16;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          frame_done;
    logic          bypass = 1'b0;
    int            chk_cnt = 0;
    int            pass_cnt = 0;
    int            in_q[$];
    int            frame_buf[$];
    int            exp_q[$];
    bit            exp_last[$];
    int            nf = 0;
    bit            fd_exp = 1'b0;
    bit            stall_prev = 1'b0;
    logic [DW-1:0] data_prev = '0;
    int            acc_in = 0;
    bit            frame_byp = 1'b0;
    int            perm[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    always #5 clk = ~clk;
    ntt8_bitrev_reorder #(.DATA_W(DW), .LOG_N(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef REORDER_BYPASS_EN
        .bypass(bypass),
`endif
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .frame_done(frame_done)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask
    task automatic step(input logic ordy);
        bit l;
        @(negedge clk);
        in_valid  = in_q.size() > 0;
        in_data   = in_valid ? DW'(in_q[0]) : '0;
        out_ready = ordy;
        #1;
        check("in_ready", in_ready, nf < 2);
        check("out_valid", out_valid, nf > 0);
        check("frame_done", frame_done, fd_exp);
        if (!out_valid) check("out_last_idle", out_last, 0);
        if (stall_prev) check("stall_hold", out_data, data_prev);
        fd_exp = 1'b0;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("out_valid_unexpected", out_valid, 0);
            else begin
                check("out_data", out_data, exp_q.pop_front());
                l = exp_last.pop_front();
                check("out_last", out_last, l);
                if (l) begin
                    nf--;
                    fd_exp = 1'b1;
                end
            end
        end
        stall_prev = out_valid && !out_ready;
        data_prev  = out_data;
        if (in_valid && in_ready) begin
            if (frame_buf.size() == 0) frame_byp = bypass;
            frame_buf.push_back(in_q.pop_front());
            acc_in++;
            if (frame_buf.size() == 8) begin
                for (int k = 0; k < 8; k++) begin
                    exp_q.push_back(frame_byp ? frame_buf[k] : frame_buf[perm[k]]);
                    exp_last.push_back(k == 7);
                end
                frame_buf.delete();
                nf++;
            end
        end
    endtask
    task automatic run(input int n, input int mode);
        for (int c = 0; c < n; c++) step(mode == 0 ? 1'b1 : mode == 1 ? 1'b0 : c[0] == 1'b0);
    endtask
    task automatic push_frame(input int base);
        for (int k = 0; k < 8; k++) in_q.push_back(base + k);
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        in_q.delete();
        frame_buf.delete();
        exp_q.delete();
        exp_last.delete();
        nf = 0;
        fd_exp = 1'b0;
        stall_prev = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_last", out_last, 0);
        check("rst_frame_done", frame_done, 0);
    endtask
    initial begin
        int a0;
        repeat (2) @(negedge clk);
        do_reset();
        push_frame(10);
        run(16, 0);
        check("single_drained", exp_q.size(), 0);
        run(2, 0);
        push_frame(10);
        push_frame(20);
        run(24, 0);
        check("b2b_no_bubble", exp_q.size(), 0);
        run(2, 0);
        a0 = acc_in;
        push_frame(40);
        push_frame(50);
        push_frame(60);
        run(30, 1);
        check("stall_accepted", acc_in - a0, 16);
        check("stall_in_ready", in_ready, 0);
        run(34, 0);
        check("stall_drained", exp_q.size() + in_q.size(), 0);
        push_frame(70);
        run(26, 2);
        check("toggle_drained", exp_q.size(), 0);
        for (int k = 0; k < 5; k++) in_q.push_back(80 + k);
        run(5, 0);
        do_reset();
        run(4, 0);
        push_frame(30);
        run(17, 0);
        check("post_rst_drained", exp_q.size(), 0);
`ifdef REORDER_BYPASS_EN
        bypass = 1'b1;
        push_frame(10);
        run(8, 0);
        bypass = 1'b0;
        push_frame(20);
        run(18, 0);
        check("bypass_drained", exp_q.size(), 0);
`endif
        run(2, 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
